// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access sequencer:
// access-size / extension codes, FSM state encodings, latched lane info,
// and the misalignment predicate used when DM_ALIGN_CHK_EN is defined.
package dm_access_ctrl_pkg;

    // Access size codes (besel)
    localparam logic [1:0] BESEL_B = 2'b00;
    localparam logic [1:0] BESEL_H = 2'b01;
    localparam logic [1:0] BESEL_W = 2'b10;

    // Load extension codes (bextop)
    localparam logic BEXTOP_ZERO = 1'b0;
    localparam logic BEXTOP_SIGN = 1'b1;

    typedef enum logic [1:0] {
        DMS_IDLE = 2'd0,
        DMS_REQ  = 2'd1,
        DMS_DONE = 2'd2
    } dm_state_e;

    // Lane information captured when a transaction starts; the load path
    // needs it again when bus_ack returns the word.
    typedef struct packed {
        logic [1:0] besel;
        logic       bextop;
        logic [1:0] off;
    } dm_lane_t;

    // Halves need addr[0]==0, words need addr[1:0]==0; bytes never misalign.
    function automatic logic misaligned(input logic [1:0] bs, input logic [1:0] off);
        logic m;
        m = 1'b0;
        case (bs)
            BESEL_B: m = 1'b0;
            BESEL_H: m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Variable-latency data-memory bus: one registered request, one-cycle ack.
interface dm_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dm_access_ctrl_lane.sv
// dm_lane: purely combinational byte-lane logic. The store side turns size
// and offset into byte enables plus lane-replicated data; the load side picks
// the addressed byte/half out of a bus word and extends it. The two sides
// have independent inputs so the caller can feed live and latched lane info.
module dm_lane
    import dm_access_ctrl_pkg::*;
(
    input  logic [1:0]  st_besel,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [1:0]  ld_besel,
    input  logic        ld_bextop,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: byte enables and replicated store data
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (st_besel)
            BESEL_B: begin
                be        = 4'b0001 << st_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            BESEL_H: begin
                be        = st_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: select the addressed lane, then sign/zero extend
    always_comb begin
        ld_byte   = rdata[{ld_off, 3'b000} +: 8];
        ld_half   = ld_off[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = rdata;
        case (ld_besel)
            BESEL_B: rdata_ext = ld_bextop ? {{24{ld_byte[7]}}, ld_byte}
                                           : {24'h0, ld_byte};
            BESEL_H: rdata_ext = ld_bextop ? {{16{ld_half[15]}}, ld_half}
                                           : {16'h0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory access sequencer. Each load/store
// runs one req/ack transaction (IDLE -> REQ -> DONE), stalling IF..MEM until
// DONE, then hands the extended load word to WB via rdata_M.
// A transaction with no ack is abandoned after TIMEOUT REQ cycles and sets
// the sticky tmo_err.
// Optional: DM_ALIGN_CHK_EN -- misaligned H/W accesses skip the bus and
// finish in DONE with align_err; otherwise the low address bits are ignored.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TCW     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_rd,
    input  logic                    mem_wr,
    input  logic [1:0]              besel,
    input  logic                    bextop,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    dm_access_ctrl_if.master        bus,
    output logic                    stall_M,
    output logic [31:0]             rdata_M,
    output logic                    done_M,
    output logic                    tmo_err,
    output logic                    align_err
);

    dm_state_e      state, state_nxt;
    logic [TCW-1:0] cnt;
    dm_lane_t       lane_q;
    logic           start;
    logic           misal;
    logic           cnt_last;
    logic [3:0]     be_w;
    logic [31:0]    wdata_w;
    logic [31:0]    rext_w;

    assign start = mem_rd | mem_wr;

`ifdef DM_ALIGN_CHK_EN
    assign misal = misaligned(besel, addr[1:0]);
`else
    assign misal = 1'b0;
`endif

    // The REQ cycle in which the incremented count reaches TIMEOUT is the
    // last one, so an unanswered request spends exactly TIMEOUT cycles in REQ.
    assign cnt_last = (cnt + TCW'(1)) == TCW'(TIMEOUT);

    assign stall_M = start && (state != DMS_DONE);
    assign done_M  = (state == DMS_DONE);

    dm_lane u_lane (
        .st_besel  (besel),
        .st_off    (addr[1:0]),
        .wdata     (wdata),
        .be        (be_w),
        .wdata_rep (wdata_w),
        .ld_besel  (lane_q.besel),
        .ld_bextop (lane_q.bextop),
        .ld_off    (lane_q.off),
        .rdata     (bus.bus_rdata),
        .rdata_ext (rext_w)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DMS_IDLE;
        else      state <= state_nxt;
    end

    // Next-state: ack has priority over timeout in the same REQ cycle
    always_comb begin
        state_nxt = state;
        case (state)
            DMS_IDLE: if (start) state_nxt = misal ? DMS_DONE : DMS_REQ;
            DMS_REQ:  if (bus.bus_ack || cnt_last) state_nxt = DMS_DONE;
            DMS_DONE: state_nxt = DMS_IDLE;
            default:  state_nxt = DMS_IDLE;
        endcase
    end

    // Bus drive, timeout counter, lane latch and load result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_be    <= 4'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_wdata <= 32'h0;
            cnt           <= '0;
            lane_q        <= '0;
            rdata_M       <= 32'h0;
            tmo_err       <= 1'b0;
        end else begin
            case (state)
                DMS_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        lane_q.besel  <= besel;
                        lane_q.bextop <= bextop;
                        lane_q.off    <= addr[1:0];
                        if (misal) begin
                            rdata_M <= 32'h0;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_wr;  // write wins over read
                            bus.bus_be    <= be_w;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_wdata <= wdata_w;
                        end
                    end
                end
                DMS_REQ: begin
                    cnt <= cnt + TCW'(1);
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                        if (!bus.bus_we) rdata_M <= rext_w;
                    end else if (cnt_last) begin
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                        tmo_err     <= 1'b1;
                        rdata_M     <= 32'h0;
                    end
                end
                DMS_DONE: cnt <= '0;
                default:  cnt <= '0;
            endcase
        end
    end

`ifdef DM_ALIGN_CHK_EN
    logic align_q;

    // Flag raised only for the DONE cycle reached by skipping the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) align_q <= 1'b0;
        else      align_q <= (state == DMS_IDLE) && start && misal;
    end

    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed + randomized bench for dm_access_ctrl. Expected values come from
// a size/offset arithmetic model of the load/store lane rules.
module tb_dm_access_ctrl;
    import dm_access_ctrl_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0, bextop = 1'b0;
    logic [1:0]  besel = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall_M, done_M, tmo_err, align_err;
    logic [31:0] rdata_M;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_tmo = 1'b0;
    int          st;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.TIMEOUT(TMO), .TCW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .besel     (besel),
        .bextop    (bextop),
        .addr      (addr),
        .wdata     (wdata),
        .bus       (bus),
        .stall_M   (stall_M),
        .rdata_M   (rdata_M),
        .done_M    (done_M),
        .tmo_err   (tmo_err),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int m_size(input logic [1:0] bs);
        return (bs == BESEL_B) ? 1 : (bs == BESEL_H) ? 2 : 4;
    endfunction

    // offset of the access inside the word, with the low bits dropped
    function automatic int m_off(input logic [1:0] bs, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        return o - (o % m_size(bs));
    endfunction

    function automatic logic m_misal(input logic [1:0] bs, input logic [31:0] a);
`ifdef DM_ALIGN_CHK_EN
        return (a % m_size(bs)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] bs, input logic [31:0] a);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 0; i < m_size(bs); i++) r[m_off(bs, a) + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] bs, input logic [31:0] wd);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_size(bs)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] bs, input logic sx,
                                           input logic [31:0] a, input logic [31:0] rw);
        logic [31:0] v;
        int s;
        s = m_size(bs);
        if (s == 4) return rw;
        v = rw >> (8 * m_off(bs, a));
        for (int i = 8 * s; i < 32; i++) v[i] = sx ? v[8*s-1] : 1'b0;
        return v;
    endfunction

    // One complete access. ack_at = index of the REQ cycle that gets the
    // ack (negative or >= TMO means never). stalls = stall_M-high cycles.
    task automatic access(input logic rd, input logic wr, input logic [1:0] bs,
                          input logic ex, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int ack_at, input string tag,
                          output int stalls);
        int   nreq;
        logic mis;
        logic acked;
        mis   = m_misal(bs, a);
        acked = (ack_at >= 0) && (ack_at < TMO);
        nreq  = acked ? ack_at + 1 : TMO;
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; besel = bs; bextop = ex;
        addr = a; wdata = wd; bus.bus_ack = 1'b0; bus.bus_rdata = rw;
        @(negedge clk);
        stalls = int'(stall_M);
        chk({tag, "/idle_req"}, bus.bus_req, 1'b0);
        chk({tag, "/idle_stall"}, stall_M, 1'b1);
        if (mis) begin
            @(posedge clk); #1;
            @(negedge clk);
            exp_rd = 32'h0;
            chk({tag, "/al_done"}, done_M, 1'b1);
            chk({tag, "/al_err"}, align_err, 1'b1);
            chk({tag, "/al_req"}, bus.bus_req, 1'b0);
            chk({tag, "/al_stall"}, stall_M, 1'b0);
            chk({tag, "/al_rdata"}, rdata_M, exp_rd);
        end else begin
            for (int i = 0; i < nreq; i++) begin
                @(posedge clk); #1;
                bus.bus_ack = (i == ack_at);
                @(negedge clk);
                stalls += int'(stall_M);
                chk({tag, "/req"}, bus.bus_req, 1'b1);
                chk({tag, "/req_done"}, done_M, 1'b0);
                chk({tag, "/we"}, bus.bus_we, wr);
                chk({tag, "/be"}, bus.bus_be, m_be(bs, a));
                chk({tag, "/addr"}, bus.bus_addr, a & 32'hFFFF_FFFC);
                chk({tag, "/wdata"}, bus.bus_wdata, m_wdata(bs, wd));
            end
            @(posedge clk); #1;
            bus.bus_ack = 1'b0;
            @(negedge clk);
            if (!acked) begin
                exp_tmo = 1'b1;
                exp_rd  = 32'h0;
            end else if (!wr) begin
                exp_rd = m_load(bs, ex, a, rw);
            end
            chk({tag, "/done"}, done_M, 1'b1);
            chk({tag, "/done_stall"}, stall_M, 1'b0);
            chk({tag, "/done_req"}, bus.bus_req, 1'b0);
            chk({tag, "/done_align"}, align_err, 1'b0);
            chk({tag, "/tmo"}, tmo_err, exp_tmo);
            chk({tag, "/rdata"}, rdata_M, exp_rd);
            chk({tag, "/stalls"}, stalls, nreq + 1);
        end
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        chk({tag, "/post_done"}, done_M, 1'b0);
        chk({tag, "/post_align"}, align_err, 1'b0);
    endtask

    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;

        // reset state
        @(negedge clk);
        chk("rst/req", bus.bus_req, 1'b0);
        chk("rst/be", bus.bus_be, 4'b0);
        chk("rst/addr", bus.bus_addr, 32'h0);
        chk("rst/done", done_M, 1'b0);
        chk("rst/rdata", rdata_M, 32'h0);
        chk("rst/tmo", tmo_err, 1'b0);
        chk("rst/stall", stall_M, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // SW with ack in the third REQ cycle
        access(1'b0, 1'b1, BESEL_W, BEXTOP_ZERO, 32'h10, 32'hDEADBEEF, 32'h0, 2, "sw", st);
        chk("sw/stall4", st, 4);

        // SB to lane 3
        access(1'b0, 1'b1, BESEL_B, BEXTOP_ZERO, 32'h13, 32'h000000A5, 32'h0, 0, "sb", st);

        // LB signed / LHU from offset 2
        access(1'b1, 1'b0, BESEL_B, BEXTOP_SIGN, 32'h22, 32'h0, 32'h00800000, 0, "lb", st);
        chk("lb/val", rdata_M, 32'hFFFFFF80);
        access(1'b1, 1'b0, BESEL_H, BEXTOP_ZERO, 32'h22, 32'h0, 32'h00800000, 1, "lhu", st);
        chk("lhu/val", rdata_M, 32'h00000080);

        // stray ack while idle is ignored
        @(posedge clk); #1;
        bus.bus_ack = 1'b1;
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("stray/done", done_M, 1'b0);
        chk("stray/req", bus.bus_req, 1'b0);

        // timeout, then sticky across a good access
        access(1'b1, 1'b0, BESEL_W, BEXTOP_ZERO, 32'h30, 32'h0, 32'h12345678, -1, "tmo", st);
        chk("tmo/stalls", st, TMO + 1);
        chk("tmo/sticky", tmo_err, 1'b1);
        access(1'b1, 1'b0, BESEL_W, BEXTOP_ZERO, 32'h34, 32'h0, 32'hCAFEF00D, 0, "tmo_lw", st);

        // reset in the middle of REQ
        @(posedge clk); #1;
        mem_rd = 1'b1; besel = BESEL_W; addr = 32'h40; bus.bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("mrst/req_before", bus.bus_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("mrst/req_async", bus.bus_req, 1'b0);
        chk("mrst/done", done_M, 1'b0);
        chk("mrst/tmo", tmo_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; mem_rd = 1'b0;
        @(negedge clk);
        chk("mrst/done_after", done_M, 1'b0);
        chk("mrst/req_after", bus.bus_req, 1'b0);
        exp_tmo = 1'b0;
        exp_rd  = 32'h0;
        access(1'b1, 1'b0, BESEL_W, BEXTOP_ZERO, 32'h44, 32'h0, 32'h0BADBEEF, 1, "mrst_lw", st);

        // misaligned word: skipped with the check, forced aligned without
        access(1'b1, 1'b0, BESEL_W, BEXTOP_ZERO, 32'h02, 32'h0, 32'h87654321, 0, "lw_mis", st);

        // randomized mix
        for (int n = 0; n < 24; n++) begin
            int          op;
            logic [1:0]  bs;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            bs = 2'($urandom_range(0, 2));
            a  = $urandom & 32'h0000_FFFF;
            access(op != 1, op != 0, bs, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   int'($urandom_range(0, 5)), "rnd", st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
